// File: rtl/warp_xwb_pkg.sv
// Shared writeback-arbiter types: source indices, queue entry layout, widths.
package warp_xwb_pkg;

    localparam int unsigned XWB_NSRC   = 4;
    localparam int unsigned XWB_RD_W   = 5;
    localparam int unsigned XWB_DATA_W = 64;

    typedef enum logic [1:0] {
        XWB_SRC_ARITH = 2'd0,
        XWB_SRC_LOGIC = 2'd1,
        XWB_SRC_MUL   = 2'd2,
        XWB_SRC_DIV   = 2'd3
    } xwb_src_e;

    typedef struct packed {
        logic [XWB_RD_W-1:0]   rd;
        logic [XWB_DATA_W-1:0] data;
    } xwb_entry_t;

endpackage

// File: rtl/warp_xwb_fifo.sv
// Single-source writeback result queue with registered occupancy credit.
module warp_xwb_fifo
    import warp_xwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  xwb_entry_t i_entry,
    input  logic       i_pop,
    output xwb_entry_t o_head,
    output logic       o_empty,
    output logic       o_credit,
    output logic       o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CREDIT_MAX = (AW+1)'(DEPTH - 2);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_d;
    logic        credit_q, credit_d;
    logic        full, do_push, do_pop;
    xwb_entry_t  mem_q [DEPTH];

    always_comb begin
        o_empty  = (wptr_q == rptr_q);
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop   = i_pop && !o_empty;
        // A full queue still takes a push when its head leaves on the same edge.
        do_push  = i_push && (!full || do_pop);
        o_drop   = i_push && full && !do_pop;
        wptr_d   = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d   = rptr_q + {{AW{1'b0}}, do_pop};
        count_d  = wptr_d - rptr_d;
        credit_d = (count_d <= CREDIT_MAX);
        o_head   = mem_q[rptr_q[AW-1:0]];
        o_credit = credit_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            credit_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= i_entry;
        end
    end

endmodule

// File: rtl/warp_xwb_arb.sv
// Round-robin writeback arbiter: four result queues onto two regfile write ports.
// Optional statistics counters enabled by WARP_XWB_STATS_EN.
module warp_xwb_arb
    import warp_xwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NSRC  = XWB_NSRC
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NSRC-1:0]              i_valid,
    input  logic [NSRC*XWB_RD_W-1:0]     i_rd,
    input  logic [NSRC*XWB_DATA_W-1:0]   i_data,
    output logic [NSRC-1:0]              o_credit,
    output logic                         o_rd1_wen,
    output logic [XWB_RD_W-1:0]          o_rd1_addr,
    output logic [XWB_DATA_W-1:0]        o_rd1_wdata,
    output logic                         o_rd2_wen,
    output logic [XWB_RD_W-1:0]          o_rd2_addr,
    output logic [XWB_DATA_W-1:0]        o_rd2_wdata,
    output logic                         o_overflow
`ifdef WARP_XWB_STATS_EN
    ,
    output logic [31:0]                  o_stat_writes,
    output logic [31:0]                  o_stat_waits
`endif
);

    localparam int unsigned SW = $clog2(NSRC);

    xwb_entry_t      push_entry [NSRC];
    xwb_entry_t      head       [NSRC];
    logic [NSRC-1:0] push, empty, drop, grant;
    logic [SW-1:0]   rr_q, rr_d;
    logic [SW-1:0]   first_idx, second_idx;
    logic            first_vld, second_vld, conflict, port2;
    logic            overflow_q, overflow_d;

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            push[s]            = i_valid[s] && (i_rd[s*XWB_RD_W +: XWB_RD_W] != '0);
            push_entry[s].rd   = i_rd[s*XWB_RD_W +: XWB_RD_W];
            push_entry[s].data = i_data[s*XWB_DATA_W +: XWB_DATA_W];
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        warp_xwb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_push   (push[g]),
            .i_entry  (push_entry[g]),
            .i_pop    (grant[g]),
            .o_head   (head[g]),
            .o_empty  (empty[g]),
            .o_credit (o_credit[g]),
            .o_drop   (drop[g])
        );
    end

    // Scan from rr; the first two non-empty heads are candidates for rd1/rd2.
    always_comb begin
        logic [SW-1:0] idx;
        first_vld  = 1'b0;
        second_vld = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        idx        = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = rr_q + k[SW-1:0];
            if (!empty[idx]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = idx;
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = idx;
                end
            end
        end
        conflict = second_vld && (head[first_idx].rd == head[second_idx].rd);
        port2    = second_vld && !conflict;

        grant = '0;
        if (first_vld) grant[first_idx] = 1'b1;
        if (port2)     grant[second_idx] = 1'b1;

        rr_d = rr_q;
        if (port2)          rr_d = second_idx + SW'(1);
        else if (first_vld) rr_d = first_idx + SW'(1);

        overflow_d = overflow_q || (|drop);
    end

    always_comb begin
        o_rd1_wen   = first_vld;
        o_rd1_addr  = '0;
        o_rd1_wdata = '0;
        o_rd2_wen   = port2;
        o_rd2_addr  = '0;
        o_rd2_wdata = '0;
        if (first_vld) begin
            o_rd1_addr  = head[first_idx].rd;
            o_rd1_wdata = head[first_idx].data;
        end
        if (port2) begin
            o_rd2_addr  = head[second_idx].rd;
            o_rd2_wdata = head[second_idx].data;
        end
        o_overflow = overflow_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef WARP_XWB_STATS_EN
    logic [31:0] writes_q, writes_d;
    logic [31:0] waits_q, waits_d;

    always_comb begin
        writes_d      = writes_q + 32'(o_rd1_wen) + 32'(o_rd2_wen);
        waits_d       = waits_q + 32'(|(~empty & ~grant));
        o_stat_writes = writes_q;
        o_stat_waits  = waits_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            writes_q <= '0;
            waits_q  <= '0;
        end else begin
            writes_q <= writes_d;
            waits_q  <= waits_d;
        end
    end
`endif

endmodule

// File: tb/tb_warp_xwb_arb.sv
// Bench for warp_xwb_arb: queue-based reference model plus directed and random stimulus.
module tb_warp_xwb_arb;

    localparam int DEPTH = 4;

    logic         i_clk;
    logic         i_rst_n;
    logic [3:0]   i_valid;
    logic [19:0]  i_rd;
    logic [255:0] i_data;
    logic [3:0]   o_credit;
    logic         o_rd1_wen, o_rd2_wen;
    logic [4:0]   o_rd1_addr, o_rd2_addr;
    logic [63:0]  o_rd1_wdata, o_rd2_wdata;
    logic         o_overflow;
`ifdef WARP_XWB_STATS_EN
    logic [31:0]  o_stat_writes, o_stat_waits;
`endif

    warp_xwb_arb #(.DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_rd        (i_rd),
        .i_data      (i_data),
        .o_credit    (o_credit),
        .o_rd1_wen   (o_rd1_wen),
        .o_rd1_addr  (o_rd1_addr),
        .o_rd1_wdata (o_rd1_wdata),
        .o_rd2_wen   (o_rd2_wen),
        .o_rd2_addr  (o_rd2_addr),
        .o_rd2_wdata (o_rd2_wdata),
        .o_overflow  (o_overflow)
`ifdef WARP_XWB_STATS_EN
        ,
        .o_stat_writes (o_stat_writes),
        .o_stat_waits  (o_stat_waits)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one queue of {rd,data} per source, rr pointer, sticky overflow.
    logic [68:0] mq [4][$];
    int          mrr   = 0;
    logic        mov   = 1'b0;
    logic [3:0]  mcred = 4'hF;

    task automatic calc(output logic e1, output logic [4:0] a1, output logic [63:0] d1,
                        output logic e2, output logic [4:0] a2, output logic [63:0] d2,
                        output int s1, output int s2);
        int found;
        logic [68:0] ent;
        found = 0; s1 = 0; s2 = 0;
        e1 = 1'b0; a1 = '0; d1 = '0; e2 = 1'b0; a2 = '0; d2 = '0;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (mrr + k) % 4;
            if (mq[s].size() > 0) begin
                if (found == 0) begin s1 = s; found = 1; end
                else if (found == 1) begin s2 = s; found = 2; end
            end
        end
        if (found >= 1) begin
            ent = mq[s1][0];
            e1 = 1'b1; a1 = ent[68:64]; d1 = ent[63:0];
        end
        if (found == 2) begin
            ent = mq[s2][0];
            if (ent[68:64] != a1) begin
                e2 = 1'b1; a2 = ent[68:64]; d2 = ent[63:0];
            end
        end
    endtask

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < 4; s++) mq[s].delete();
            mrr = 0; mov = 1'b0; mcred = 4'hF;
        end else begin
            logic e1, e2;
            logic [4:0] a1, a2;
            logic [63:0] d1, d2;
            int s1, s2;
            int pre [4];
            logic [3:0] popped;
            calc(e1, a1, d1, e2, a2, d2, s1, s2);
            for (int s = 0; s < 4; s++) pre[s] = mq[s].size();
            popped = '0;
            if (e1) begin void'(mq[s1].pop_front()); popped[s1] = 1'b1; end
            if (e2) begin void'(mq[s2].pop_front()); popped[s2] = 1'b1; end
            for (int s = 0; s < 4; s++) begin
                if (i_valid[s] && i_rd[s*5 +: 5] != 5'd0) begin
                    if (pre[s] < DEPTH || popped[s]) mq[s].push_back({i_rd[s*5 +: 5], i_data[s*64 +: 64]});
                    else mov = 1'b1;
                end
            end
            if (e2) mrr = (s2 + 1) % 4;
            else if (e1) mrr = (s1 + 1) % 4;
            for (int s = 0; s < 4; s++) mcred[s] = (mq[s].size() <= DEPTH - 2);
        end
    end

    // Per-cycle comparison against the model, mid-cycle away from the clock edge.
    always @(negedge i_clk) begin
        logic e1, e2;
        logic [4:0] a1, a2;
        logic [63:0] d1, d2;
        int s1, s2;
        calc(e1, a1, d1, e2, a2, d2, s1, s2);
        chk("m_rd1_wen",   64'(o_rd1_wen),   64'(e1));
        chk("m_rd1_addr",  64'(o_rd1_addr),  64'(a1));
        chk("m_rd1_wdata", o_rd1_wdata,      d1);
        chk("m_rd2_wen",   64'(o_rd2_wen),   64'(e2));
        chk("m_rd2_addr",  64'(o_rd2_addr),  64'(a2));
        chk("m_rd2_wdata", o_rd2_wdata,      d2);
        chk("m_credit",    64'(o_credit),    64'(mcred));
        chk("m_overflow",  64'(o_overflow),  64'(mov));
    end

    task automatic push(input int s, input logic [4:0] rd, input logic [63:0] d);
        i_valid[s]      = 1'b1;
        i_rd[s*5 +: 5]  = rd;
        i_data[s*64 +: 64] = d;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_valid = '0; i_rd = '0; i_data = '0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        i_valid = '0; i_rd = '0; i_data = '0; i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_wen1",   64'(o_rd1_wen), 64'd0);
        chk("rst_wen2",   64'(o_rd2_wen), 64'd0);
        chk("rst_addr1",  64'(o_rd1_addr), 64'd0);
        chk("rst_credit", 64'(o_credit), 64'hF);
        chk("rst_ovf",    64'(o_overflow), 64'd0);
        i_rst_n = 1'b1;

        // Single push: visible the next cycle, gone the cycle after.
        push(0, 5'd5, 64'h1234); tick();
        chk("single_wen1",  64'(o_rd1_wen), 64'd1);
        chk("single_addr1", 64'(o_rd1_addr), 64'd5);
        chk("single_data1", o_rd1_wdata, 64'h1234);
        chk("single_wen2",  64'(o_rd2_wen), 64'd0);
        tick();
        chk("single_idle1", 64'(o_rd1_wen), 64'd0);
        chk("single_idle2", 64'(o_rd2_wen), 64'd0);

        // All four at once from rr=0.
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 5'(s + 1), 64'hA0 + 64'(s));
        tick();
        chk("all_c1_addr1", 64'(o_rd1_addr), 64'd1);
        chk("all_c1_data1", o_rd1_wdata, 64'hA0);
        chk("all_c1_addr2", 64'(o_rd2_addr), 64'd2);
        chk("all_c1_data2", o_rd2_wdata, 64'hA1);
        tick();
        chk("all_c2_addr1", 64'(o_rd1_addr), 64'd3);
        chk("all_c2_addr2", 64'(o_rd2_addr), 64'd4);
        tick();
        chk("all_c3_wen1", 64'(o_rd1_wen), 64'd0);
        // rr back at 0: src0 must beat src3 for port 1.
        push(0, 5'd9, 64'h9); push(3, 5'd10, 64'h10); tick();
        chk("rr0_addr1", 64'(o_rd1_addr), 64'd9);
        chk("rr0_addr2", 64'(o_rd2_addr), 64'd10);
        tick();

        // rd conflict with rr=1.
        push(0, 5'd6, 64'h6); tick();
        push(1, 5'd7, 64'h71); push(2, 5'd7, 64'h72); tick();
        chk("conf_wen1",  64'(o_rd1_wen), 64'd1);
        chk("conf_addr1", 64'(o_rd1_addr), 64'd7);
        chk("conf_data1", o_rd1_wdata, 64'h71);
        chk("conf_wen2",  64'(o_rd2_wen), 64'd0);
        tick();
        chk("conf2_data1", o_rd1_wdata, 64'h72);
        chk("conf2_wen2",  64'(o_rd2_wen), 64'd0);
        tick();
        chk("conf3_wen1", 64'(o_rd1_wen), 64'd0);

        // rd=0 is discarded.
        push(3, 5'd0, 64'hDEAD); tick();
        chk("rd0_wen1",   64'(o_rd1_wen), 64'd0);
        chk("rd0_wen2",   64'(o_rd2_wen), 64'd0);
        chk("rd0_credit", 64'(o_credit[3]), 64'd1);

        // Continuous pushes on all sources fill the queues.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            for (int s = 0; s < 4; s++) push(s, 5'(s + 1), 64'(i * 16 + s));
            tick();
            if (i == 3) chk("fill_e3_credit", 64'(o_credit), 64'hF);
            if (i == 4) chk("fill_e4_credit", 64'(o_credit), 64'h3);
            if (i == 6) chk("fill_e6_credit", 64'(o_credit), 64'h0);
            if (i == 7) chk("fill_e7_ovf", 64'(o_overflow), 64'd0);
            if (i == 8) chk("fill_e8_ovf", 64'(o_overflow), 64'd1);
        end
        repeat (10) tick();
        chk("ovf_sticky", 64'(o_overflow), 64'd1);

        // Reset with queued entries.
        do_reset();
        for (int s = 0; s < 3; s++) push(s, 5'(s + 20), 64'(s));
        tick();
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_wen1", 64'(o_rd1_wen), 64'd0);
        chk("mid_rst_wen2", 64'(o_rd2_wen), 64'd0);
        @(posedge i_clk); #3;
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_credit", 64'(o_credit), 64'hF);
        chk("post_rst_wen1", 64'(o_rd1_wen), 64'd0);
        tick();
        chk("post_rst_wen2", 64'(o_rd2_wen), 64'd0);

        // Random phases with varying density and rd spread.
        for (int p = 0; p < 3; p++) begin
            int dens, rdmax;
            dens  = (p == 0) ? 30 : (p == 1) ? 60 : 90;
            rdmax = (p == 1) ? 3 : 31;
            do_reset();
            for (int c = 0; c < 1000; c++) begin
                for (int s = 0; s < 4; s++)
                    if ($urandom_range(0, 99) < dens)
                        push(s, 5'($urandom_range(0, rdmax)), {$urandom, $urandom});
                tick();
            end
            repeat (10) tick();
        end

        @(negedge i_clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
